// File: rtl/rll_2_7_pkg.sv
// Shared RLL(2,7) definitions: code table, FSM states and register sizes.
// Used by both the write-path encoder and the read-path decoder.
package rll_2_7_pkg;

  localparam int unsigned CODE_W         = 8;
  localparam int unsigned BUF_W          = 11;
  localparam int unsigned MARK_WIDTH_DEF = 16;

  // Code words are MSB-aligned in the CODE_W-bit code register
  localparam logic [CODE_W-1:0] CODE_10   = 8'b0100_0000;
  localparam logic [CODE_W-1:0] CODE_11   = 8'b1000_0000;
  localparam logic [CODE_W-1:0] CODE_000  = 8'b0001_0000;
  localparam logic [CODE_W-1:0] CODE_010  = 8'b1001_0000;
  localparam logic [CODE_W-1:0] CODE_011  = 8'b0010_0000;
  localparam logic [CODE_W-1:0] CODE_0010 = 8'b0010_0100;
  localparam logic [CODE_W-1:0] CODE_0011 = 8'b0000_1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_MARK
  } state_e;

endpackage

// File: rtl/rll_2_7_group_lut.sv
// Parses the leading data bits into one RLL(2,7) group. With pad set, bits
// beyond count are taken as 0 so a residual tail still forms a group.
module rll_2_7_group_lut
  import rll_2_7_pkg::*;
(
  input  logic [3:0]        data_msb,
  input  logic [3:0]        count,
  input  logic              pad,
  output logic              group_valid,
  output logic [2:0]        data_len,
  output logic [CODE_W-1:0] code,
  output logic [3:0]        code_len
);

  logic [3:0] bits;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      bits[3-i] = data_msb[3-i] & (count > 4'(i));
    end
    data_len = 3'd3;
    code     = CODE_000;
    code_len = 4'd6;
    if (bits[3]) begin
      data_len = 3'd2;
      code_len = 4'd4;
      code     = bits[2] ? CODE_11 : CODE_10;
    end else if (bits[2]) begin
      code = bits[1] ? CODE_011 : CODE_010;
    end else if (bits[1]) begin
      data_len = 3'd4;
      code_len = 4'd8;
      code     = bits[0] ? CODE_0011 : CODE_0010;
    end
    // Decisive bits always lie inside the first data_len bits
    group_valid = pad ? (count != 4'd0) : (count >= {1'b0, data_len});
  end

endmodule

// File: rtl/rll_2_7_encoder.sv
// RLL(2,7) write-path encoder: bytes in over valid/ready, one code bit out per
// bit_tick, with flush padding and verbatim address-mark insertion.
module rll_2_7_encoder
  import rll_2_7_pkg::*;
#(
  parameter int unsigned MARK_WIDTH = MARK_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  bit_tick,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic                  mark_req,
  input  logic [MARK_WIDTH-1:0] mark_pattern,
  output logic                  code_bit,
  output logic                  code_valid,
  output logic                  busy,
  output logic                  mark_done,
  output logic                  underrun
);

  localparam int unsigned        MCNT_W   = $clog2(MARK_WIDTH + 1);
  localparam logic [MCNT_W-1:0]  MARK_LEN = MCNT_W'(MARK_WIDTH);

  state_e                  state_q, state_d;
  logic [BUF_W-1:0]        buf_q, buf_d, buf_c;
  logic [3:0]              cnt_q, cnt_d, cnt_c;
  logic [CODE_W-1:0]       code_q, code_d;
  logic [3:0]              ccnt_q, ccnt_d;
  logic [MARK_WIDTH-1:0]   mark_q, mark_d;
  logic [MCNT_W-1:0]       mcnt_q, mcnt_d;
  logic                    mpend_q, mpend_d;
  logic                    ready_en_q, ready_en_d;
  logic                    code_bit_q, code_bit_d;
  logic                    code_valid_q, code_valid_d;
  logic                    underrun_q, underrun_d;
  logic                    mark_done_q, mark_done_d;

  logic                    grp_valid;
  logic [2:0]              grp_data_len;
  logic [CODE_W-1:0]       grp_code;
  logic [3:0]              grp_code_len;
  logic                    tick, accept, streaming;

  rll_2_7_group_lut u_lut (
    .data_msb    (buf_q[BUF_W-1 -: 4]),
    .count       (cnt_q),
    .pad         (state_q == ST_FLUSH),
    .group_valid (grp_valid),
    .data_len    (grp_data_len),
    .code        (grp_code),
    .code_len    (grp_code_len)
  );

  assign in_ready  = ready_en_q && enable && (cnt_q <= 4'd3) &&
                     (state_q == ST_IDLE || state_q == ST_RUN);
  assign tick      = enable && bit_tick;
  assign accept    = in_valid && in_ready;
  assign streaming = (state_q == ST_RUN) || (state_q == ST_FLUSH);

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    cnt_d        = cnt_q;
    code_d       = code_q;
    ccnt_d       = ccnt_q;
    mark_d       = mark_q;
    mcnt_d       = mcnt_q;
    mpend_d      = mpend_q;
    ready_en_d   = 1'b1;
    code_bit_d   = 1'b0;
    code_valid_d = 1'b0;
    underrun_d   = 1'b0;
    mark_done_d  = 1'b0;
    buf_c        = buf_q;
    cnt_c        = cnt_q;

    if (enable) begin
      if (streaming && ccnt_q == 4'd0) begin
        if (tick) begin
          code_valid_d = 1'b1;
          underrun_d   = 1'b1;
        end
        if (grp_valid) begin
          code_d = grp_code;
          ccnt_d = grp_code_len;
          buf_c  = buf_q << grp_data_len;
          cnt_c  = (cnt_q > {1'b0, grp_data_len}) ? cnt_q - {1'b0, grp_data_len} : '0;
        end
      end else if (streaming && tick) begin
        code_bit_d   = code_q[CODE_W-1];
        code_valid_d = 1'b1;
        code_d       = code_q << 1;
        ccnt_d       = ccnt_q - 4'd1;
      end

      // New byte lands directly behind whatever residual survives this cycle
      if (accept) begin
        buf_c = buf_c | ({in_data, 3'b000} >> cnt_c);
        cnt_c = cnt_c + 4'd8;
      end
      buf_d = buf_c;
      cnt_d = cnt_c;

      if (mark_req && state_q != ST_MARK) begin
        mark_d  = mark_pattern;
        mpend_d = 1'b1;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_d = ST_RUN;
          end else if (mark_req || mpend_q) begin
            state_d = ST_MARK;
            mcnt_d  = MARK_LEN;
            mpend_d = 1'b0;
          end
        end
        ST_RUN: begin
          if (flush) begin
            state_d = ST_FLUSH;
          end else if (mpend_q && cnt_q == 4'd0 && ccnt_q == 4'd0 && !accept) begin
            state_d = ST_MARK;
            mcnt_d  = MARK_LEN;
            mpend_d = 1'b0;
          end
        end
        ST_FLUSH: begin
          if (cnt_q == 4'd0 && ccnt_q == 4'd0) begin
            if (mpend_q || mark_req) begin
              state_d = ST_MARK;
              mcnt_d  = MARK_LEN;
              mpend_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_MARK: begin
          if (mcnt_q == '0) begin
            mark_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else if (tick) begin
            code_bit_d   = mark_q[MARK_WIDTH-1];
            code_valid_d = 1'b1;
            mark_d       = mark_q << 1;
            mcnt_d       = mcnt_q - MCNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      buf_q        <= '0;
      cnt_q        <= '0;
      code_q       <= '0;
      ccnt_q       <= '0;
      mark_q       <= '0;
      mcnt_q       <= '0;
      mpend_q      <= 1'b0;
      ready_en_q   <= 1'b0;
      code_bit_q   <= 1'b0;
      code_valid_q <= 1'b0;
      underrun_q   <= 1'b0;
      mark_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      code_q       <= code_d;
      ccnt_q       <= ccnt_d;
      mark_q       <= mark_d;
      mcnt_q       <= mcnt_d;
      mpend_q      <= mpend_d;
      ready_en_q   <= ready_en_d;
      code_bit_q   <= code_bit_d;
      code_valid_q <= code_valid_d;
      underrun_q   <= underrun_d;
      mark_done_q  <= mark_done_d;
    end
  end

  assign code_bit   = code_bit_q;
  assign code_valid = code_valid_q;
  assign underrun   = underrun_q;
  assign mark_done  = mark_done_q;
  assign busy       = (cnt_q != 4'd0) || (ccnt_q != 4'd0) || mpend_q ||
                      (state_q == ST_FLUSH) || (state_q == ST_MARK);

endmodule

// File: tb/tb_rll_2_7_encoder.sv
// Scoreboard bench for rll_2_7_encoder: a table-driven reference encoder
// queues expected code bits; a negedge monitor pops and compares them.
module tb_rll_2_7_encoder;

  localparam int unsigned MW = 16;

  logic          clk = 1'b0;
  logic          reset_n, enable, bit_tick, in_valid, in_ready, flush, mark_req;
  logic [7:0]    in_data;
  logic [MW-1:0] mark_pattern;
  logic          code_bit, code_valid, busy, mark_done, underrun;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit          sb_q[$];
  bit          data_bits[$];
  logic [7:0]  tx_q[$];
  bit          tick_en = 1'b0;
  bit          underrun_ok = 1'b0;
  bit          rl_on = 1'b0;
  bit          seen_one = 1'b0;
  bit          prev_cv = 1'b0;
  bit          en_prev = 1'b1;
  bit          exp_bit;
  int unsigned zeros = 0;
  int unsigned underrun_seen = 0;
  int unsigned mark_done_seen = 0;
  int unsigned gap_cnt = 0;

  // Data/code table of the RLL(2,7) code, right-aligned values with lengths
  int unsigned td [7] = '{2, 3, 0, 2, 3, 2, 3};
  int unsigned tdl[7] = '{2, 2, 3, 3, 3, 4, 4};
  int unsigned tc [7] = '{4, 8, 4, 36, 8, 36, 8};
  int unsigned tcl[7] = '{4, 4, 6, 6, 6, 8, 8};

  always #5 clk = ~clk;

  rll_2_7_encoder #(.MARK_WIDTH(MW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .bit_tick     (bit_tick),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .flush        (flush),
    .mark_req     (mark_req),
    .mark_pattern (mark_pattern),
    .code_bit     (code_bit),
    .code_valid   (code_valid),
    .busy         (busy),
    .mark_done    (mark_done),
    .underrun     (underrun)
  );

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) data_bits.push_back(b[k]);
  endtask

  // Greedy prefix match against the table; past the end the data reads as 0
  task automatic model_encode();
    int unsigned i;
    bit          hit, b, found;
    i = 0;
    while (i < data_bits.size()) begin
      found = 1'b0;
      for (int unsigned e = 0; e < 7 && !found; e++) begin
        hit = 1'b1;
        for (int unsigned k = 0; k < tdl[e]; k++) begin
          b = (i + k < data_bits.size()) ? data_bits[i+k] : 1'b0;
          if (b != (((td[e] >> (tdl[e] - 1 - k)) & 1) != 0)) hit = 1'b0;
        end
        if (hit) begin
          for (int unsigned k = 0; k < tcl[e]; k++)
            sb_q.push_back(((tc[e] >> (tcl[e] - 1 - k)) & 1) != 0);
          i += tdl[e];
          found = 1'b1;
        end
      end
      if (!found) i = data_bits.size();
    end
    data_bits.delete();
  endtask

  task automatic push_mark(input logic [MW-1:0] pat);
    for (int k = MW - 1; k >= 0; k--) sb_q.push_back(pat[k]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", n < 2000, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_ctl(input bit f, input bit m, input logic [MW-1:0] pat);
    flush        = f;
    mark_req     = m;
    mark_pattern = pat;
    @(negedge clk);
    flush    = 1'b0;
    mark_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int unsigned n;
    n = 0;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_busy_fall"}, busy, 0);
    repeat (3) @(negedge clk);
    check({name, "_all_bits_out"}, sb_q.size(), 0);
  endtask

  task automatic run_data(input string name, input bit pause);
    foreach (tx_q[i]) push_byte(tx_q[i]);
    model_encode();
    seen_one      = 1'b0;
    rl_on         = 1'b1;
    underrun_seen = 0;
    send_byte(tx_q[0]);
    repeat (3) @(negedge clk);
    tick_en = 1'b1;
    for (int unsigned i = 1; i < tx_q.size(); i++) send_byte(tx_q[i]);
    pulse_ctl(1'b1, 1'b0, '0);
    if (pause) begin
      repeat (4) @(negedge clk);
      enable = 1'b0;
      repeat (12) @(negedge clk);
      enable = 1'b1;
    end
    wait_idle(name);
    tick_en = 1'b0;
    check({name, "_no_underrun"}, underrun_seen, 0);
    tx_q.delete();
  endtask

  // Tick strobe with random spacing of 2..5 clk
  initial begin
    bit_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_en && gap_cnt == 0) begin
        bit_tick = 1'b1;
        gap_cnt  = $urandom_range(1, 4);
      end else begin
        bit_tick = 1'b0;
        if (gap_cnt > 0) gap_cnt--;
      end
    end
  end

  // Monitor: pops the scoreboard on every non-underrun code bit
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (!en_prev && !enable)
          check("frozen_outputs", {code_valid, underrun, mark_done}, 0);
        if (underrun) begin
          underrun_seen++;
          check("underrun_allowed", underrun_ok, 1);
          check("underrun_bit", {code_valid, code_bit}, 2);
        end else if (code_valid) begin
          check("bit_expected", sb_q.size() != 0, 1);
          if (sb_q.size() != 0) begin
            exp_bit = sb_q.pop_front();
            check("code_bit", code_bit, exp_bit);
            if (rl_on) begin
              if (code_bit) begin
                if (seen_one) check("rll_zero_run", (zeros >= 2) && (zeros <= 7), 1);
                seen_one = 1'b1;
                zeros    = 0;
              end else begin
                zeros++;
              end
            end
          end
        end
        if (mark_done) begin
          mark_done_seen++;
          check("mark_done_after_last_bit", {prev_cv, sb_q.size() == 0}, 3);
        end
        prev_cv = code_valid;
      end
      en_prev = enable;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MW-1:0] pat;
    reset_n      = 1'b1;
    enable       = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    flush        = 1'b0;
    mark_req     = 1'b0;
    mark_pattern = '0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_code_bit", code_bit, 0);
    check("rst_code_valid", code_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_mark_done", mark_done, 0);
    check("rst_underrun", underrun, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1 check("in_ready_at_release", in_ready, 0);
    @(negedge clk);
    check("in_ready_after_release", in_ready, 1);

    tx_q = '{8'hFF}; run_data("byte_ff", 1'b0);
    tx_q = '{8'h12}; run_data("byte_12", 1'b0);
    tx_q = '{8'h00}; run_data("byte_00", 1'b0);
    for (int unsigned r = 0; r < 5; r++) begin
      for (int unsigned i = 0; i < $urandom_range(3, 8); i++) tx_q.push_back(8'($urandom));
      run_data("rand_stream", r == 1);
    end

    // Mark requested in IDLE goes straight out
    rl_on          = 1'b0;
    mark_done_seen = 0;
    push_mark(16'h4489);
    tick_en = 1'b1;
    pulse_ctl(1'b0, 1'b1, 16'h4489);
    wait_idle("mark_idle");
    tick_en = 1'b0;
    check("mark_idle_done_count", mark_done_seen, 1);

    // Flush and mark together: data drains first, then the mark
    mark_done_seen = 0;
    pat = MW'($urandom);
    push_byte(8'($urandom));
    model_encode();
    push_mark(pat);
    send_byte(8'($urandom) & 8'h00 | 8'h00);
    sb_q.delete();
    push_byte(8'h00);
    model_encode();
    push_mark(pat);
    repeat (3) @(negedge clk);
    tick_en = 1'b1;
    pulse_ctl(1'b1, 1'b1, pat);
    wait_idle("flush_mark");
    tick_en = 1'b0;
    check("flush_mark_done_count", mark_done_seen, 1);

    // Underrun once buffered data runs dry without a flush
    underrun_ok   = 1'b1;
    underrun_seen = 0;
    for (int unsigned i = 0; i < 2; i++) begin
      tx_q.push_back(8'($urandom));
      push_byte(tx_q[i]);
    end
    model_encode();
    send_byte(tx_q[0]);
    repeat (3) @(negedge clk);
    tick_en = 1'b1;
    send_byte(tx_q[1]);
    for (int unsigned n = 0; n < 2000 && underrun_seen == 0; n++) @(negedge clk);
    check("underrun_fired", underrun_seen > 0, 1);
    pulse_ctl(1'b1, 1'b0, '0);
    wait_idle("underrun");
    tick_en     = 1'b0;
    underrun_ok = 1'b0;
    tx_q.delete();

    // Asynchronous reset mid-group with a byte buffered
    push_byte(8'hB5);
    model_encode();
    send_byte(8'hB5);
    repeat (3) @(negedge clk);
    tick_en = 1'b1;
    repeat (9) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_code_bit", code_bit, 0);
    check("midrst_code_valid", code_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_mark_done", mark_done, 0);
    check("midrst_underrun", underrun, 0);
    tick_en = 1'b0;
    sb_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready_after", in_ready, 1);
    tx_q = '{8'hFF}; run_data("after_reset_ff", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
